// File: rtl/seg_mux_decoder.sv
// Receive side of a 4-digit multiplexed 7-segment bus.
// Filters the scanned strobes and rebuilds whole MM:SS frames.
module seg_mux_decoder #(
  parameter int STABLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 65536,
  parameter int TO_W        = 17
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] DIG_N,
  input  logic [6:0] SEG,
  output logic [3:0] MT,
  output logic [3:0] MU,
  output logic [3:0] ST,
  output logic [3:0] SU,
  output logic       FRAME_VALID,
  output logic       SEG_ERR,
  output logic       LOST
);

  localparam int CNT_W = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;

  typedef enum logic {COLLECT, COMPLETE} state_t;

  logic [3:0]       dig_s1_q, dig_s1_d, dig_s2_q, dig_s2_d;
  logic [6:0]       seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             armed_q, armed_d;
  state_t           state_q, state_d;
  logic [3:0]       mask_q, mask_d;
  logic             bad_q, bad_d;
  logic [3:0][3:0]  shadow_q, shadow_d;
  logic [3:0][3:0]  out_q, out_d;
  logic [TO_W-1:0]  timer_q, timer_d;
  logic             fv_q, fv_d;
  logic             err_q, err_d;
  logic             lost_q, lost_d;

  logic       changed, slot_ok, at_top, accept, dig_ok;
  logic [1:0] slot;
  logic [3:0] dec;

  // Change is seen on the edge that loads s2, so a new value
  // starts counting the moment it appears in the second stage.
  always_comb begin
    dig_s1_d = DIG_N;
    seg_s1_d = SEG;
    dig_s2_d = dig_s1_q;
    seg_s2_d = seg_s1_q;
    changed  = (dig_s1_q != dig_s2_q) || (seg_s1_q != seg_s2_q);
    slot_ok  = $onehot(~dig_s2_q);
    at_top   = (cnt_q == CNT_W'(STABLE_CYC - 1));
    accept   = slot_ok && at_top && armed_q && (state_q == COLLECT);
  end

  always_comb begin
    if (changed)     cnt_d = '0;
    else if (at_top) cnt_d = cnt_q;
    else             cnt_d = cnt_q + 1'b1;
    armed_d = armed_q;
    if (accept) armed_d = 1'b0;
    if (changed || !slot_ok) armed_d = 1'b1;
  end

  always_comb begin
    slot = '0;
    for (int i = 0; i < 4; i++) begin
      if (!dig_s2_q[i]) slot = 2'(i);
    end
  end

  always_comb begin
    dig_ok = 1'b1;
    dec    = '0;
    unique case (seg_s2_q)
      7'h7E:   dec = 4'd0;
      7'h30:   dec = 4'd1;
      7'h6D:   dec = 4'd2;
      7'h79:   dec = 4'd3;
      7'h33:   dec = 4'd4;
      7'h5B:   dec = 4'd5;
      7'h5F:   dec = 4'd6;
      7'h70:   dec = 4'd7;
      7'h7F:   dec = 4'd8;
      7'h7B:   dec = 4'd9;
      default: dig_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    bad_d    = bad_q;
    shadow_d = shadow_q;
    out_d    = out_q;
    timer_d  = timer_q;
    lost_d   = lost_q;
    fv_d     = 1'b0;
    err_d    = 1'b0;
    if (accept) begin
      timer_d      = '0;
      mask_d[slot] = 1'b1;
      if (dig_ok) begin
        shadow_d[slot] = dec;
      end else begin
        bad_d = 1'b1;
        err_d = 1'b1;
      end
      if (mask_d == 4'hF) state_d = COMPLETE;
    end else if (timer_q == TO_W'(TIMEOUT_CYC - 1)) begin
      timer_d = '0;
      mask_d  = '0;
      bad_d   = 1'b0;
      lost_d  = 1'b1;
    end else begin
      timer_d = timer_q + 1'b1;
    end
    unique case (state_q)
      COLLECT: ;
      COMPLETE: begin
        state_d = COLLECT;
        mask_d  = '0;
        bad_d   = 1'b0;
        if (!bad_q) begin
          out_d  = shadow_q;
          fv_d   = 1'b1;
          lost_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      dig_s1_q <= 4'hF;
      dig_s2_q <= 4'hF;
      seg_s1_q <= '0;
      seg_s2_q <= '0;
      cnt_q    <= '0;
      armed_q  <= 1'b1;
      state_q  <= COLLECT;
      mask_q   <= '0;
      bad_q    <= 1'b0;
      shadow_q <= '0;
      out_q    <= '0;
      timer_q  <= '0;
      fv_q     <= 1'b0;
      err_q    <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      dig_s1_q <= dig_s1_d;
      dig_s2_q <= dig_s2_d;
      seg_s1_q <= seg_s1_d;
      seg_s2_q <= seg_s2_d;
      cnt_q    <= cnt_d;
      armed_q  <= armed_d;
      state_q  <= state_d;
      mask_q   <= mask_d;
      bad_q    <= bad_d;
      shadow_q <= shadow_d;
      out_q    <= out_d;
      timer_q  <= timer_d;
      fv_q     <= fv_d;
      err_q    <= err_d;
      lost_q   <= lost_d;
    end
  end

  assign MT          = out_q[3];
  assign MU          = out_q[2];
  assign ST          = out_q[1];
  assign SU          = out_q[0];
  assign FRAME_VALID = fv_q;
  assign SEG_ERR     = err_q;
  assign LOST        = lost_q;

endmodule

// File: tb/tb_seg_mux_decoder.sv
// Bench for seg_mux_decoder: table of frames plus
// hand sequences for glitches, timeout, reset and order.
module tb_seg_mux_decoder;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] DIG_N = 4'hF;
  logic [6:0] SEG = '0;
  logic [3:0] MT, MU, ST, SU;
  logic       FRAME_VALID, SEG_ERR, LOST;

  seg_mux_decoder #(
    .STABLE_CYC (4),
    .TIMEOUT_CYC(64),
    .TO_W       (7)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .DIG_N      (DIG_N),
    .SEG        (SEG),
    .MT         (MT),
    .MU         (MU),
    .ST         (ST),
    .SU         (SU),
    .FRAME_VALID(FRAME_VALID),
    .SEG_ERR    (SEG_ERR),
    .LOST       (LOST)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0][6:0] pats;
    logic [15:0]     exp;
    bit              fv;
    int              errs;
  } row_t;

  int ntotal = 0;
  int nbad = 0;
  int cycn = 0;
  int fv_cnt = 0;
  int err_cnt = 0;
  int last_fv = -1;
  int exp_fv = 0;
  int exp_err = 0;
  logic [15:0] sbq[$];

  always @(posedge CLK) cycn <= cycn + 1;

  function automatic logic [6:0] sg(input int d);
    case (d)
      0: return 7'h7E;
      1: return 7'h30;
      2: return 7'h6D;
      3: return 7'h79;
      4: return 7'h33;
      5: return 7'h5B;
      6: return 7'h5F;
      7: return 7'h70;
      8: return 7'h7F;
      default: return 7'h7B;
    endcase
  endfunction

  function automatic logic [3:0][6:0] mk(
    input logic [6:0] a, input logic [6:0] b,
    input logic [6:0] c, input logic [6:0] d);
    logic [3:0][6:0] r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    ntotal++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic slot(input int s, input logic [6:0] p,
                      input int n);
    logic [3:0] one;
    one = 4'b0001;
    DIG_N = ~(one << (4 - s));
    SEG = p;
    repeat (n) tick();
  endtask

  task automatic blank(input int n);
    DIG_N = 4'hF;
    SEG = '0;
    repeat (n) tick();
  endtask

  task automatic outs_chk(input string nm, input logic [15:0] e);
    chk(nm, {16'h0, MT, MU, ST, SU}, {16'h0, e});
  endtask

  task automatic run_frame(input string nm,
                           input logic [3:0][6:0] pats,
                           input logic [15:0] e,
                           input bit fv, input int errs);
    int cl;
    cl = 0;
    for (int s = 0; s < 4; s++) begin
      if (s == 3) begin
        cl = cycn;
        if (fv) sbq.push_back(e);
      end
      slot(s + 1, pats[s], 8);
    end
    blank(3);
    if (fv) exp_fv++;
    exp_err += errs;
    outs_chk({nm, "_outs"}, e);
    chk({nm, "_fvcnt"}, fv_cnt, exp_fv);
    chk({nm, "_errcnt"}, err_cnt, exp_err);
    if (fv) chk({nm, "_latency"}, last_fv, cl + 7);
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      if (SEG_ERR) err_cnt++;
      if (FRAME_VALID) begin
        fv_cnt++;
        last_fv = cycn;
        if (sbq.size() == 0) begin
          ntotal++;
          nbad++;
          $display("FAIL unexpected_frame got=%h",
                   {MT, MU, ST, SU});
        end else begin
          chk("frame", {16'h0, MT, MU, ST, SU},
              {16'h0, sbq.pop_front()});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t tbl[5];
    int c3;
    tbl[0] = '{mk(sg(1), sg(2), sg(3), sg(4)), 16'h1234, 1'b1, 0};
    tbl[1] = '{mk(sg(1), sg(2), 7'h01, sg(4)), 16'h1234, 1'b0, 1};
    tbl[2] = '{mk(sg(5), sg(9), sg(0), sg(7)), 16'h5907, 1'b1, 0};
    tbl[3] = '{mk(sg(0), sg(0), sg(0), sg(0)), 16'h0000, 1'b1, 0};
    tbl[4] = '{mk(sg(9), sg(8), sg(6), sg(5)), 16'h9865, 1'b1, 0};

    repeat (3) tick();
    outs_chk("reset_outs", 16'h0);
    chk("reset_fv", FRAME_VALID, 0);
    chk("reset_err", SEG_ERR, 0);
    chk("reset_lost", LOST, 0);
    RST = 1'b0;
    blank(2);

    for (int i = 0; i < 5; i++) begin
      run_frame($sformatf("row%0d", i), tbl[i].pats,
                tbl[i].exp, tbl[i].fv, tbl[i].errs);
    end

    // glitch after accept and ghost overlaps
    slot(1, sg(1), 7);
    SEG = 7'h00;
    tick();
    SEG = sg(1);
    repeat (2) tick();
    DIG_N = 4'b0011;
    repeat (3) tick();
    slot(2, sg(2), 8);
    DIG_N = 4'b1001;
    SEG = sg(3);
    repeat (3) tick();
    slot(3, sg(3), 8);
    sbq.push_back(16'h1234);
    slot(4, sg(4), 8);
    blank(3);
    exp_fv++;
    outs_chk("ghost_outs", 16'h1234);
    chk("ghost_fvcnt", fv_cnt, exp_fv);
    chk("ghost_errcnt", err_cnt, exp_err);

    // free order with a repeated slot
    slot(4, sg(9), 8);
    slot(1, sg(1), 8);
    slot(3, sg(5), 8);
    slot(1, sg(2), 8);
    chk("order_early", fv_cnt, exp_fv);
    sbq.push_back(16'h2059);
    slot(2, sg(0), 8);
    blank(3);
    exp_fv++;
    outs_chk("order_outs", 16'h2059);
    chk("order_fvcnt", fv_cnt, exp_fv);

    // long strobe: one accept, then timeout fires
    slot(2, sg(2), 200);
    blank(2);
    chk("hold_lost", LOST, 1);
    chk("hold_fvcnt", fv_cnt, exp_fv);
    chk("hold_errcnt", err_cnt, exp_err);
    run_frame("relock", mk(sg(1), sg(2), sg(3), sg(4)),
              16'h1234, 1'b1, 0);
    chk("relock_lost", LOST, 0);
    slot(1, sg(7), 8);
    slot(2, sg(7), 8);
    c3 = cycn;
    slot(3, sg(7), 8);
    blank(1);
    while (cycn < c3 + 69) tick();
    chk("to_before", LOST, 0);
    tick();
    chk("to_after", LOST, 1);
    chk("to_fvcnt", fv_cnt, exp_fv);
    outs_chk("to_outs", 16'h1234);
    run_frame("after_to", mk(sg(4), sg(3), sg(2), sg(1)),
              16'h4321, 1'b1, 0);
    chk("after_to_lost", LOST, 0);

    // reset mid-frame
    slot(1, sg(6), 8);
    slot(2, sg(6), 8);
    RST = 1'b1;
    DIG_N = 4'hF;
    SEG = '0;
    tick();
    outs_chk("rst_outs", 16'h0);
    chk("rst_fv", FRAME_VALID, 0);
    repeat (2) tick();
    RST = 1'b0;
    slot(3, sg(8), 8);
    slot(4, sg(8), 8);
    blank(3);
    chk("rst_nostale", fv_cnt, exp_fv);
    sbq.push_back(16'h8888);
    slot(1, sg(8), 8);
    slot(2, sg(8), 8);
    blank(3);
    exp_fv++;
    outs_chk("rst_outs8", 16'h8888);
    chk("rst_fvcnt", fv_cnt, exp_fv);

    chk("sb_empty", sbq.size(), 0);
    chk("err_total", err_cnt, 1);
    $display("test done: total=%0d bad=%0d", ntotal, nbad);
    $finish;
  end

endmodule
